// File: rtl/fp_muldiv_pkg.sv
// fp_muldiv_pkg: shared state encoding, flag layout and opcode constants for the FP32 mul/div arbiter
package fp_muldiv_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
    localparam int FLAG_W = 5;
    localparam int FLAG_IO = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_I = 0;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/fp_muldiv_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant; pointer flips to the other requester on every grant
module rr_arbiter2 (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_grant,
    output logic       o_id
);
    logic r_rr;
    always_comb begin
        o_grant = !i_grant_en ? 2'b00 : (&i_req) ? (r_rr ? 2'b10 : 2'b01) : i_req;
        o_id    = o_grant[1];
    end
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            r_rr <= 1'b0;
        else if (|o_grant)
            r_rr <= ~o_id;
    end
endmodule

// File: rtl/fp_muldiv_arbiter.sv
// fp_muldiv_arbiter: round-robin sharing of one fixed-latency FP32 mul/div unit between two requesters; FP_ARB_STICKY_FLAGS_EN adds per-requester sticky flags
module fp_muldiv_arbiter
    import fp_muldiv_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int CNT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic              i_req_sel0,
    input  logic              i_req_sel1,
    input  logic [31:0]       i_req_a0,
    input  logic [31:0]       i_req_b0,
    input  logic [31:0]       i_req_a1,
    input  logic [31:0]       i_req_b1,
    output logic              o_fpu_en,
    output logic              o_fpu_sel,
    output logic [31:0]       o_fpu_a,
    output logic [31:0]       o_fpu_b,
    input  logic [31:0]       i_fpu_R,
    input  logic [FLAG_W-1:0] i_fpu_flags,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic              o_rsp_id,
    output logic [31:0]       o_rsp_R,
    output logic [FLAG_W-1:0] o_rsp_flags,
`ifdef FP_ARB_STICKY_FLAGS_EN
    output logic [FLAG_W-1:0] o_sticky_flags0,
    output logic [FLAG_W-1:0] o_sticky_flags1,
    input  logic [1:0]        i_sticky_clr,
`endif
    output logic              o_busy
);
    if (LAT < 1 || LAT > 15 || (1 << CNT_W) <= LAT) begin : g_bad_cfg
        $error("fp_muldiv_arbiter: LAT must be 1..15 and fit in CNT_W bits");
    end

    arb_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sel, r_id;
    logic [31:0]       r_a, r_b, r_rsp_R;
    logic [FLAG_W-1:0] r_rsp_flags;
    logic [1:0]        w_grant;
    logic              w_gid, w_last, w_hs;

    rr_arbiter2 u_rr (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_req      (i_req_valid),
        .i_grant_en (r_state == IDLE),
        .o_grant    (w_grant),
        .o_id       (w_gid)
    );

    always_comb begin
        w_next      = r_state;
        w_last      = r_cnt == CNT_W'(LAT - 1);
        w_hs        = r_state == RESP && i_rsp_ready;
        o_req_ready = w_grant;
        o_fpu_en    = r_state == EXEC;
        o_rsp_valid = r_state == RESP;
        o_busy      = r_state != IDLE;
        o_fpu_sel   = r_sel;
        o_fpu_a     = r_a;
        o_fpu_b     = r_b;
        o_rsp_id    = r_id;
        o_rsp_R     = r_rsp_R;
        o_rsp_flags = r_rsp_flags;
        case (r_state)
            IDLE:    w_next = |w_grant ? EXEC : IDLE;
            EXEC:    w_next = w_last ? RESP : EXEC;
            RESP:    w_next = i_rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // operands stay latched after EXEC so the unit inputs never glitch while a response waits
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_id        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_R     <= '0;
            r_rsp_flags <= '0;
        end else begin
            r_state <= w_next;
            if (|w_grant) begin
                r_sel <= w_gid ? i_req_sel1 : i_req_sel0;
                r_a   <= w_gid ? i_req_a1 : i_req_a0;
                r_b   <= w_gid ? i_req_b1 : i_req_b0;
                r_id  <= w_gid;
                r_cnt <= '0;
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_rsp_R     <= i_fpu_R;
                    r_rsp_flags <= i_fpu_flags;
                end
            end
        end
    end

`ifdef FP_ARB_STICKY_FLAGS_EN
    logic [1:0][FLAG_W-1:0] r_sticky;
    assign o_sticky_flags0 = r_sticky[0];
    assign o_sticky_flags1 = r_sticky[1];
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            r_sticky <= '0;
        else
            for (int i = 0; i < 2; i++)
                r_sticky[i] <= (w_hs && r_id == 1'(i)) ? (r_sticky[i] | r_rsp_flags) :
                               i_sticky_clr[i] ? '0 : r_sticky[i];
    end
`else
    logic w_unused;
    assign w_unused = w_hs;
`endif
endmodule

// File: tb/tb_fp_muldiv_arbiter.sv
// tb_fp_muldiv_arbiter: scoreboard bench with a behavioural FPU and arbitration reference model
module tb_fp_muldiv_arbiter;
    localparam int LAT = 3;

    logic        clk = 1'b0, arst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready;
    logic        sel0 = 1'b0, sel1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        fpu_en, fpu_sel;
    logic [31:0] fpu_a, fpu_b, fpu_R;
    logic [4:0]  fpu_flags;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, busy;
    logic [31:0] rsp_R;
    logic [4:0]  rsp_flags;
`ifdef FP_ARB_STICKY_FLAGS_EN
    logic [4:0]  sticky0, sticky1;
    logic [1:0]  sticky_clr = '0;
`endif

    fp_muldiv_arbiter #(.LAT(LAT), .CNT_W(4)) dut (
        .i_clk(clk), .i_arst(arst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_sel0(sel0), .i_req_sel1(sel1), .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
        .o_fpu_en(fpu_en), .o_fpu_sel(fpu_sel), .o_fpu_a(fpu_a), .o_fpu_b(fpu_b),
        .i_fpu_R(fpu_R), .i_fpu_flags(fpu_flags),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
        .o_rsp_R(rsp_R), .o_rsp_flags(rsp_flags),
`ifdef FP_ARB_STICKY_FLAGS_EN
        .o_sticky_flags0(sticky0), .o_sticky_flags1(sticky1), .i_sticky_clr(sticky_clr),
`endif
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // simplified FP32 unit: normal operands only, truncating, result {R, flags}
    function automatic logic [36:0] fpu_fn(logic s, logic [31:0] a, logic [31:0] b);
        logic sg;
        int ea, eb, e;
        logic [47:0] p, n, d;
        logic [22:0] m;
        logic inx;
        sg = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (s && b[30:0] == 0)
            return (a[30:0] == 0) ? {32'h7FC00000, 5'b10000} : {sg, 8'hFF, 23'h0, 5'b01000};
        if (a[30:23] == 0 || (!s && b[30:23] == 0))
            return {sg, 31'h0, 5'b00000};
        if (!s) begin
            p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
            if (p[47]) begin m = p[46:24]; e = ea + eb - 126; inx = |p[23:0]; end
            else begin m = p[45:23]; e = ea + eb - 127; inx = |p[22:0]; end
        end else begin
            n = {1'b1, a[22:0], 24'h0};
            d = {24'h0, 1'b1, b[22:0]};
            p = n / d;
            inx = (n % d) != 0;
            if (p[24]) begin m = p[23:1]; e = ea - eb + 127; inx = inx | p[0]; end
            else begin m = p[22:0]; e = ea - eb + 126; end
        end
        if (e >= 255) return {sg, 8'hFF, 23'h0, 5'b00100};
        if (e <= 0) return {sg, 31'h0, 5'b00010};
        return {sg, e[7:0], m, 4'b0, inx};
    endfunction

    // the unit only presents a valid result in its LAT-th enabled cycle
    int ecnt;
    always @(posedge clk or posedge arst)
        if (arst) ecnt <= 0;
        else ecnt <= fpu_en ? ecnt + 1 : 0;
    always_comb {fpu_R, fpu_flags} = (fpu_en && ecnt == LAT - 1) ? fpu_fn(fpu_sel, fpu_a, fpu_b) : {32'hDEADBEEF, 5'b10101};

    typedef struct packed {logic id; logic s; logic [31:0] a, b, r; logic [4:0] f;} exp_t;
    exp_t q[$];
    logic g_log[$];
    int checks = 0, errors = 0, cyc = 0;
    logic m_rr = 1'b0, m_busy = 1'b0;
    int m_gcyc = 0, last_gcyc = -1;
    bit contention = 1'b0;
    logic [1:0] acc = '0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // reference model: grant prediction, protocol timing, expected-response push
    always @(negedge clk) begin
        logic [1:0] eg;
        logic id;
        int dd;
        exp_t e;
        cyc++;
        acc = arst ? 2'b00 : (req_ready & req_valid);
        if (arst) begin
            q.delete();
            m_busy = 1'b0;
            m_rr = 1'b0;
            last_gcyc = -1;
        end else if (!m_busy) begin
            eg = (&req_valid) ? (m_rr ? 2'b10 : 2'b01) : req_valid;
            chk("req_ready_idle", 128'(req_ready), 128'(eg));
            chk("idle_outputs", 128'({fpu_en, busy, rsp_valid}), 128'(0));
            if (|eg) begin
                id = eg[1];
                e.id = id;
                e.s = id ? sel1 : sel0;
                e.a = id ? a1 : a0;
                e.b = id ? b1 : b0;
                {e.r, e.f} = fpu_fn(e.s, e.a, e.b);
                q.push_back(e);
                g_log.push_back(id);
                if (contention && last_gcyc >= 0) chk("issue_interval", 128'(cyc - last_gcyc), 128'(LAT + 2));
                last_gcyc = cyc;
                m_rr = ~id;
                m_busy = 1'b1;
                m_gcyc = cyc;
            end
        end else begin
            dd = cyc - m_gcyc;
            chk("req_ready_busy", 128'(req_ready), 128'(0));
            chk("busy", 128'(busy), 128'(1));
            chk("fpu_en", 128'(fpu_en), 128'(dd <= LAT));
            chk("rsp_valid", 128'(rsp_valid), 128'(dd > LAT));
            chk("fpu_operands", 128'({fpu_sel, fpu_a, fpu_b}), 128'({q[$].s, q[$].a, q[$].b}));
            if (dd > LAT && rsp_ready) m_busy = 1'b0;
        end
    end

    // monitor: compares every presented response with the scoreboard head, pops on handshake
    always begin
        @(negedge clk);
        #2;
        if (!arst && rsp_valid) begin
            if (q.size() == 0) chk("rsp_unexpected", 128'(1), 128'(0));
            else begin
                chk("rsp_fields", 128'({rsp_id, rsp_R, rsp_flags}), 128'({q[0].id, q[0].r, q[0].f}));
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int i, logic s, logic [31:0] a, logic [31:0] b);
        if (i == 0) begin sel0 = s; a0 = a; b0 = b; end
        else begin sel1 = s; a1 = a; b1 = b; end
    endtask

    task automatic issue(int i, logic s, logic [31:0] a, logic [31:0] b);
        int n;
        load(i, s, a, b);
        req_valid[i] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
        if (!req_ready[i]) chk("issue_timeout", 128'(0), 128'(1));
        tick();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
        if (!rsp_valid) chk("rsp_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        int lat, n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 128'({req_ready, fpu_en, fpu_sel, fpu_a, fpu_b, rsp_valid, rsp_id, rsp_R, rsp_flags, busy}), 128'(0));
        arst = 1'b0;
        rsp_ready = 1'b1;
        tick();

        issue(0, 1'b0, 32'h40000000, 32'h40400000);
        wait_rsp(lat);
        chk("mul_latency", 128'(lat), 128'(LAT + 1));
        chk("mul_result", 128'({rsp_id, rsp_R, rsp_flags}), 128'({1'b0, 32'h40C00000, 5'b00000}));
        tick();

        issue(1, 1'b1, 32'h3F800000, 32'h00000000);
        wait_rsp(lat);
        chk("div0_result", 128'({rsp_id, rsp_R, rsp_flags}), 128'({1'b1, 32'h7F800000, 5'b01000}));
        tick();

        arst = 1'b1;
        load(0, 1'b0, $urandom, $urandom);
        load(1, 1'b1, $urandom, $urandom);
        req_valid = 2'b11;
        tick();
        g_log.delete();
        contention = 1'b1;
        arst = 1'b0;
        repeat (22) begin
            tick();
            for (int i = 0; i < 2; i++) if (acc[i]) load(i, 1'($urandom), $urandom, $urandom);
        end
        contention = 1'b0;
        req_valid = 2'b00;
        chk("contention_count", 128'(g_log.size() >= 4), 128'(1));
        for (int k = 0; k < 4 && k < g_log.size(); k++) chk("contention_order", 128'(g_log[k]), 128'(k % 2));
        repeat (8) tick();

        rsp_ready = 1'b0;
        issue(0, 1'b1, 32'h3F800000, 32'h40400000);
        load(1, 1'b0, 32'h40000000, 32'h40000000);
        req_valid[1] = 1'b1;
        wait_rsp(lat);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", 128'({rsp_valid, req_ready, fpu_en, rsp_id, rsp_R, rsp_flags}), 128'({1'b1, 2'b00, 1'b0, 1'b0, 32'h3EAAAAAA, 5'b00001}));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(rsp_valid), 128'(1));
        @(negedge clk);
        chk("bp_complete", 128'({rsp_valid, busy, req_ready}), 128'({2'b00, 2'b10}));
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        tick();

        issue(0, 1'b0, $urandom, $urandom);
        @(posedge clk);
        #2;
        chk("pre_reset_en", 128'(fpu_en), 128'(1));
        #1;
        arst = 1'b1;
        #1;
        chk("reset_async", 128'({fpu_en, busy, rsp_valid}), 128'(0));
        load(0, 1'b1, $urandom, $urandom);
        load(1, 1'b0, $urandom, $urandom);
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        arst = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 0 && n < 20);
        chk("grant_after_reset", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        repeat (12) tick();

        for (int c = 0; c < 400; c++) begin
            tick();
            rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < 2; i++)
                if (acc[i] || (!req_valid[i] && ($urandom % 3) == 0)) begin
                    req_valid[i] = acc[i] ? 1'($urandom) : 1'b1;
                    load(i, 1'($urandom), $urandom, $urandom);
                end
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        n = 0;
        while ((busy || q.size() != 0) && n < 50) begin tick(); n++; end
        chk("drain", 128'({busy, q.size() != 0}), 128'(0));

`ifdef FP_ARB_STICKY_FLAGS_EN
        sticky_clr = 2'b11;
        tick();
        sticky_clr = 2'b00;
        issue(0, 1'b0, 32'h7E800000, 32'h7E800000);
        wait_rsp(lat);
        issue(0, 1'b1, 32'h3F800000, 32'h40400000);
        wait_rsp(lat);
        tick();
        @(negedge clk);
        chk("sticky_set", 128'(sticky0), 128'(5'b00101));
        chk("sticky_other", 128'(sticky1), 128'(0));
        tick();
        sticky_clr = 2'b01;
        tick();
        sticky_clr = 2'b00;
        @(negedge clk);
        chk("sticky_clr", 128'(sticky0), 128'(0));
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog cycle %0d: got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
